// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: reset vector, NOP encoding,
// fetch-entry layout and a small alignment helper.
package ifetch_queue_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  // One buffered fetch as seen by decode.
  typedef struct packed {
    logic              trap;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction memory request/response bus. The fetch unit is the master; the
// memory is the slave. Requests are valid/ready; responses are in order and
// never back-pressured.
interface ifetch_queue_if
  import ifetch_queue_pkg::*;
;
  logic              req_valid;
  logic              req_ready;
  logic [PC_W-1:0]   req_addr;
  logic              rsp_valid;
  logic [INST_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ifq_fifo.sv
// In-order fetch buffer. A slot is reserved (pc recorded) when a request fires
// and filled with the instruction word when its response returns; the head is
// visible to decode only once filled. Flush empties the buffer and can load a
// single pre-filled entry into slot 0 in the same cycle.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_load_valid,
  input  logic [PC_W-1:0]   i_load_pc,
  input  logic              i_rsv_valid,
  input  logic [PC_W-1:0]   i_rsv_pc,
  input  logic              i_fill_valid,
  input  logic [INST_W-1:0] i_fill_inst,
  input  logic              i_pop,
  output logic              o_head_valid,
  output fetch_entry_t      o_head,
  output logic [CW-1:0]     o_used,
  output logic [CW-1:0]     o_inflight
);

  // Three pointers: rd <= fill <= rsv. [rd,fill) filled, [fill,rsv) awaiting data.
  logic [CW-1:0] rd_q, rd_d, fill_q, fill_d, rsv_q, rsv_d;
  logic [AW-1:0] rd_idx, fill_idx, rsv_idx;
  logic          rsv_en, fill_en, pop_en;

  logic              trap_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  assign rd_idx   = rd_q[AW-1:0];
  assign fill_idx = fill_q[AW-1:0];
  assign rsv_idx  = rsv_q[AW-1:0];

  assign o_used       = rsv_q - rd_q;
  assign o_inflight   = rsv_q - fill_q;
  assign o_head_valid = fill_q != rd_q;

  assign rsv_en  = i_rsv_valid  & ~i_flush & (o_used != CW'(DEPTH));
  assign fill_en = i_fill_valid & ~i_flush & (o_inflight != '0);
  assign pop_en  = i_pop        & ~i_flush & o_head_valid;

  assign o_head.trap = trap_mem[rd_idx];
  assign o_head.pc   = pc_mem[rd_idx];
  assign o_head.inst = inst_mem[rd_idx];

  // Pointer next-state; flush restarts all pointers, optionally with slot 0 filled.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    rd_d   = rd_q;
    fill_d = fill_q;
    rsv_d  = rsv_q;
    if (i_flush) begin
      rd_d   = '0;
      fill_d = i_load_valid ? CW'(1) : '0;
      rsv_d  = fill_d;
    end else begin
      if (pop_en)  rd_d   = rd_q   + CW'(1);
      if (fill_en) fill_d = fill_q + CW'(1);
      if (rsv_en)  rsv_d  = rsv_q  + CW'(1);
    end
  end

  // Pointer registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q   <= '0;
      fill_q <= '0;
      rsv_q  <= '0;
    end else begin
      rd_q   <= rd_d;
      fill_q <= fill_d;
      rsv_q  <= rsv_d;
    end
  end

  // Entry storage: pc/trap written at reserve, instruction written at fill.
  // NOTE: storage is deliberately not reset; the pointers alone define which slots are valid.
  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      if (i_load_valid) begin
        trap_mem[0] <= 1'b1;
        pc_mem[0]   <= i_load_pc;
        inst_mem[0] <= '0;
      end
    end else begin
      if (rsv_en) begin
        trap_mem[rsv_idx] <= 1'b0;
        pc_mem[rsv_idx]   <= i_rsv_pc;
      end
      if (fill_en) inst_mem[fill_idx] <= i_fill_inst;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction fetch front end. Owns the PC, keeps up to DEPTH fetches
// in flight or buffered, and presents {inst, pc} to decode in program order.
// A redirect flushes the buffer and squashes responses still owed by memory.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (misaligned redirect becomes
// a single trap-marker entry and fetch stops until the next redirect).
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_VECTOR,
  parameter int          DEPTH      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ifetch_queue_if.master       imem,
  output logic                 o_inst_valid,
  input  logic                 i_inst_ready,
  output logic [INST_W-1:0]    o_inst,
  output logic [PC_W-1:0]      o_inst_pc,
  output logic                 o_inst_trap,
  input  logic                 i_redirect_valid,
  input  logic [PC_W-1:0]      i_redirect_pc,
  input  logic                 i_halt
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   squash_q, squash_d;
  logic            stopped_q, stopped_d;

  logic [CW-1:0]   used, inflight, outstanding;
  logic            head_valid;
  fetch_entry_t    head;

  logic            req_valid, req_fire, rsp_keep, pop, trap_load;
  logic [PC_W-1:0] redirect_target;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign trap_load       = i_redirect_valid & is_misaligned(i_redirect_pc);
  assign redirect_target = i_redirect_pc;
  assign o_inst_trap     = head_valid & head.trap;
`else
  logic unused_trap;
  assign trap_load       = 1'b0;
  assign redirect_target = {i_redirect_pc[PC_W-1:2], 2'b00};
  assign o_inst_trap     = 1'b0;
  assign unused_trap     = head.trap;
`endif

  // Issue is a pure function of state and level inputs, so a raised request
  // holds with a stable address until it fires, unless halt/redirect drop it.
  assign req_valid = ~i_rst & ~i_halt & ~i_redirect_valid & ~stopped_q & (used < DEPTH_C);
  assign req_fire  = req_valid & imem.req_ready;
  assign rsp_keep  = imem.rsp_valid & ~i_redirect_valid & (squash_q == '0);
  assign pop       = head_valid & i_inst_ready & ~i_redirect_valid;

  // Responses still owed by memory: stale ones plus those for live requests.
  // Memory round trip must keep this below 2**CW.
  assign outstanding = squash_q + inflight;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_redirect_valid),
    .i_load_valid (trap_load),
    .i_load_pc    (i_redirect_pc),
    .i_rsv_valid  (req_fire),
    .i_rsv_pc     (pc_q),
    .i_fill_valid (rsp_keep),
    .i_fill_inst  (imem.rsp_data),
    .i_pop        (pop),
    .o_head_valid (head_valid),
    .o_head       (head),
    .o_used       (used),
    .o_inflight   (inflight)
  );

  // Next PC, squash count and stop flag; redirect overrides everything else.
  always_comb begin
    pc_d      = pc_q;
    squash_d  = squash_q;
    stopped_d = stopped_q;
    if (i_redirect_valid) begin
      pc_d      = redirect_target;
      stopped_d = trap_load;
      squash_d  = (imem.rsp_valid && outstanding != '0) ? outstanding - CW'(1) : outstanding;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem.rsp_valid && squash_q != '0) squash_d = squash_q - CW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q      <= RESET_ADDR;
      squash_q  <= '0;
      stopped_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      squash_q  <= squash_d;
      stopped_q <= stopped_d;
    end
  end

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc_q;

  // Outputs are forced to zero when the head is empty.
  assign o_inst_valid = head_valid;
  assign o_inst       = head_valid ? head.inst : '0;
  assign o_inst_pc    = head_valid ? head.pc   : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order memory model with random
// latency plus a transaction-level model of the decode-side stream.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, inst_ready, inst_trap;
  logic [31:0] inst, inst_pc;
  logic        redir_v, halt;
  logic [31:0] redir_pc;

  always #5 clk = ~clk;

  ifetch_queue_if imem ();

  ifetch_queue #(.RESET_ADDR(RST_PC), .DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .imem             (imem),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_inst_trap      (inst_trap),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .i_halt           (halt)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic        trap;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  mreq_t       mq[$];   // requests accepted by memory, oldest first
  exp_t        eq[$];   // entries decode should see, oldest first
  int          epoch, cyc, live, last_due, lat_min, lat_max;
  logic [31:0] exp_req;
  bit          stopped_m;
  int          tests, fails;

  bit          last_fire, last_pop;
  logic [31:0] last_pop_pc;
  logic        last_pop_trap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[3:2] == 2'b11) return NOP_WORD;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // One clock: called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    bit          exp_rv, fire, pop, rsp_v;
    logic [31:0] faddr;
    exp_t        t;
    mreq_t       m;
    int          due;
    rsp_v = (mq.size() > 0) && (mq[0].due <= cyc);
    imem.rsp_valid = rsp_v;
    imem.rsp_data  = 32'h0;
    if (rsp_v) imem.rsp_data = mem_word(mq[0].addr);
    #1;
    exp_rv = !halt && !redir_v && !stopped_m && (live < DEPTH);
    tests++;
    if (imem.req_valid !== exp_rv) begin
      fails++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem.req_valid, exp_rv);
    end
    if (exp_rv) begin
      tests++;
      if (imem.req_addr !== exp_req) begin
        fails++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem.req_addr, exp_req);
      end
    end
    tests++;
    if (inst_valid !== (eq.size() > 0)) begin
      fails++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, eq.size() > 0);
    end
    if (eq.size() > 0) begin
      tests++;
      if ({inst_trap, inst_pc, inst} !== {eq[0].trap, eq[0].pc, eq[0].inst}) begin
        fails++;
        $display("FAIL head cyc=%0d got trap=%b pc=%h inst=%h exp trap=%b pc=%h inst=%h",
                 cyc, inst_trap, inst_pc, inst, eq[0].trap, eq[0].pc, eq[0].inst);
      end
    end else begin
      tests++;
      if ({inst_trap, inst_pc, inst} !== 65'd0) begin
        fails++;
        $display("FAIL idle_out cyc=%0d got trap=%b pc=%h inst=%h exp 0", cyc, inst_trap, inst_pc, inst);
      end
    end
    fire  = imem.req_valid && imem.req_ready;
    faddr = imem.req_addr;
    pop   = inst_valid && inst_ready && !redir_v;
    last_fire = fire; last_pop = pop; last_pop_pc = inst_pc; last_pop_trap = inst_trap;
    @(posedge clk);
    if (redir_v) begin
      eq.delete(); epoch++; live = 0; stopped_m = 0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      exp_req = redir_pc;
      if (redir_pc[1:0] != 2'b00) begin
        t.trap = 1'b1; t.pc = redir_pc; t.inst = 32'h0;
        eq.push_back(t); live = 1; stopped_m = 1;
      end
`else
      exp_req = {redir_pc[31:2], 2'b00};
`endif
    end else begin
      if (pop && eq.size() > 0) begin eq.delete(0); live--; end
      if (rsp_v && mq[0].epoch == epoch) begin
        t.trap = 1'b0; t.pc = mq[0].addr; t.inst = mem_word(mq[0].addr);
        eq.push_back(t);
      end
      if (fire) begin live++; exp_req += 32'd4; end
    end
    if (rsp_v) mq.delete(0);
    if (fire) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      m.addr = faddr; m.epoch = epoch; m.due = due;
      mq.push_back(m);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1; redir_v = 1'b0; redir_pc = 32'h0; halt = 1'b0; inst_ready = 1'b0;
    imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      tests++;
      if (imem.req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got=%b exp=0", imem.req_valid); end
      tests++;
      if (imem.req_addr !== RST_PC) begin fails++; $display("FAIL rst_req_addr got=%h exp=%h", imem.req_addr, RST_PC); end
      tests++;
      if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
      tests++;
      if ({inst_trap, inst_pc, inst} !== 65'd0) begin
        fails++; $display("FAIL rst_outputs got trap=%b pc=%h inst=%h exp 0", inst_trap, inst_pc, inst);
      end
    end
    mq.delete(); eq.delete(); epoch++; live = 0; stopped_m = 0;
    exp_req = RST_PC; last_due = cyc;
    rst = 1'b0;
  endtask

  task automatic wait_pop(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      cycle();
      if (last_pop) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    imem.req_ready = 1'b1; inst_ready = 1'b1; lat_min = 1; lat_max = 3;
    for (int c = 0; c < 8; c++) cycle();
    do_reset(1'b1);
  endtask

  task automatic test_stream();
    int          first, n;
    logic [31:0] pcs [4];
    do_reset(1'b0);
    imem.req_ready = 1'b1; inst_ready = 1'b1; lat_min = 1; lat_max = 1;
    first = -1; n = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (last_pop) begin
        if (n < 4) pcs[n] = last_pop_pc;
        if (first < 0) first = c;
        n++;
      end
    end
    tests++;
    if (first != 2) begin fails++; $display("FAIL stream_latency got=%0d exp=2", first); end
    tests++;
    if (n != 10) begin fails++; $display("FAIL stream_no_gaps got=%0d pops exp=10", n); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (pcs[i] !== RST_PC + 32'(4 * i)) begin
        fails++; $display("FAIL stream_pc%0d got=%h exp=%h", i, pcs[i], RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    int fires;
    bit got;
    do_reset(1'b0);
    imem.req_ready = 1'b1; inst_ready = 1'b0; lat_min = 1; lat_max = 2;
    fires = 0;
    for (int c = 0; c < 10; c++) begin cycle(); fires += int'(last_fire); end
    tests++;
    if (fires != DEPTH) begin fails++; $display("FAIL bp_fires got=%0d exp=%0d", fires, DEPTH); end
    tests++;
    if (imem.req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_low got=%b exp=0", imem.req_valid); end
    inst_ready = 1'b1;
    wait_pop(20, got);
    tests++;
    if (!got) begin fails++; $display("FAIL bp_release timeout got=no pop exp=pop"); end
    else begin
      tests++;
      if (last_pop_pc !== RST_PC) begin fails++; $display("FAIL bp_first_pc got=%h exp=%h", last_pop_pc, RST_PC); end
    end
    for (int c = 0; c < 6; c++) begin cycle(); fires += int'(last_fire); end
    tests++;
    if (fires <= DEPTH) begin fails++; $display("FAIL bp_resume got=%0d fires exp>%0d", fires, DEPTH); end
  endtask

  task automatic test_redirect_inflight();
    bit got;
    do_reset(1'b0);
    imem.req_ready = 1'b1; inst_ready = 1'b1; lat_min = 4; lat_max = 4;
    for (int c = 0; c < 3; c++) cycle();
    redir_v = 1'b1; redir_pc = 32'h0000_0100;
    cycle();
    redir_v = 1'b0;
    wait_pop(30, got);
    tests++;
    if (!got) begin fails++; $display("FAIL redir_inflight timeout got=no pop exp=pop"); end
    else begin
      tests++;
      if (last_pop_pc !== 32'h100) begin fails++; $display("FAIL redir_inflight_pc got=%h exp=00000100", last_pop_pc); end
    end
  endtask

  task automatic test_redirect_collision();
    bit got;
    do_reset(1'b0);
    imem.req_ready = 1'b1; inst_ready = 1'b1; lat_min = 2; lat_max = 2;
    for (int c = 0; c < 2; c++) cycle();
    redir_v = 1'b1; redir_pc = 32'h0000_0040;
    cycle();
    tests++;
    if (last_fire) begin fails++; $display("FAIL collide_fire got=1 exp=0"); end
    redir_v = 1'b0;
    wait_pop(20, got);
    tests++;
    if (!got) begin fails++; $display("FAIL collide timeout got=no pop exp=pop"); end
    else begin
      tests++;
      if (last_pop_pc !== 32'h40) begin fails++; $display("FAIL collide_pc got=%h exp=00000040", last_pop_pc); end
    end
  endtask

  task automatic test_halt();
    int fires, pops;
    do_reset(1'b0);
    imem.req_ready = 1'b1; inst_ready = 1'b1; lat_min = 3; lat_max = 3;
    for (int c = 0; c < 2; c++) cycle();
    halt = 1'b1; fires = 0; pops = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(); fires += int'(last_fire); pops += int'(last_pop);
    end
    tests++;
    if (fires != 0) begin fails++; $display("FAIL halt_fires got=%0d exp=0", fires); end
    tests++;
    if (pops != 2) begin fails++; $display("FAIL halt_drain got=%0d exp=2", pops); end
    halt = 1'b0;
  endtask

  task automatic test_misalign();
    bit got;
    do_reset(1'b0);
    imem.req_ready = 1'b1; inst_ready = 1'b1; lat_min = 1; lat_max = 3;
    for (int c = 0; c < 4; c++) cycle();
    redir_v = 1'b1; redir_pc = 32'h0000_0102;
    cycle();
    redir_v = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    begin
      int fires, pops;
      logic [31:0] tpc;
      logic        ttrap;
      fires = 0; pops = 0; tpc = 32'h0; ttrap = 1'b0;
      for (int c = 0; c < 12; c++) begin
        cycle(); fires += int'(last_fire);
        if (last_pop) begin pops++; tpc = last_pop_pc; ttrap = last_pop_trap; end
      end
      tests++;
      if (fires != 0) begin fails++; $display("FAIL trap_stopped got=%0d fires exp=0", fires); end
      tests++;
      if (pops != 1 || tpc !== 32'h102 || ttrap !== 1'b1) begin
        fails++; $display("FAIL trap_entry got pops=%0d pc=%h trap=%b exp pops=1 pc=00000102 trap=1", pops, tpc, ttrap);
      end
      redir_v = 1'b1; redir_pc = 32'h0000_0200;
      cycle();
      redir_v = 1'b0;
      wait_pop(20, got);
      tests++;
      if (!got || last_pop_pc !== 32'h200 || last_pop_trap !== 1'b0) begin
        fails++; $display("FAIL trap_resume got pop=%b pc=%h trap=%b exp pop=1 pc=00000200 trap=0", got, last_pop_pc, last_pop_trap);
      end
    end
`else
    wait_pop(20, got);
    tests++;
    if (!got || last_pop_pc !== 32'h100 || last_pop_trap !== 1'b0) begin
      fails++; $display("FAIL misalign_align got pop=%b pc=%h trap=%b exp pop=1 pc=00000100 trap=0", got, last_pop_pc, last_pop_trap);
    end
`endif
  endtask

  task automatic test_random();
    int          pops;
    logic [31:0] r;
    do_reset(1'b0);
    lat_min = 1; lat_max = 4; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      imem.req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(3, 0) != 0);
      if ($urandom_range(49, 0) == 0) halt = ~halt;
      redir_v = ($urandom_range(39, 0) == 0);
      if (redir_v) begin
        r = $urandom;
        case ($urandom_range(7, 0))
          0:       redir_pc = 32'hFFFF_FFF0;
          1:       redir_pc = {r[31:2], 2'b00} | 32'(1 + $urandom_range(2, 0));
          default: redir_pc = {r[31:2], 2'b00};
        endcase
      end
      cycle();
      pops += int'(last_pop);
    end
    redir_v = 1'b0; halt = 1'b0;
    tests++;
    if (pops < 200) begin fails++; $display("FAIL random_progress got=%0d pops exp>=200", pops); end
  endtask

  initial begin
    tests = 0; fails = 0; epoch = 0; cyc = 0; live = 0; last_due = 0;
    lat_min = 1; lat_max = 1; exp_req = RST_PC; stopped_m = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_halt();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
